// File: rtl/spi_slave_byte.sv
// SPI slave byte endpoint, fully oversampled in the i_Clk domain (no logic on SCK).
// Receives MSB-first bytes on MOSI and returns a single-entry-queued byte on MISO.
module spi_slave_byte #(
  parameter int         SPI_MODE    = 0,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_MISO_En,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready
);
  localparam logic CPOL = ((SPI_MODE >> 1) & 1) == 1;
  localparam logic CPHA = (SPI_MODE & 1) == 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   lead, trail, sample_edge, shift_edge, cs_fall;

  state_t     state, state_nxt;
  logic       live, samp, byte_start, drop;
  logic [7:0] tx_shift, holding, rx_shift, rx_byte;
  logic       full, skip, rx_dv;
  logic [2:0] cnt;

  // Synchronizers reset to idle bus levels so no phantom edge follows reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= CPOL;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead        = (sck_s != CPOL) && (sck_d == CPOL);
  assign trail       = (sck_s == CPOL) && (sck_d != CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign cs_fall     = cs_d && !cs_s;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    live       = 1'b0;
    samp       = 1'b0;
    byte_start = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt  = ACTIVE;
          byte_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_nxt = IDLE;
          drop      = 1'b1;
        end else begin
          live       = 1'b1;
          samp       = sample_edge;
          byte_start = sample_edge && (cnt == 3'd7);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_shift <= '0;
      holding  <= '0;
      full     <= 1'b0;
      skip     <= 1'b0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_dv    <= 1'b0;
      cnt      <= '0;
    end else begin
      rx_dv <= 1'b0;

      // A load arriving with the byte start that empties nothing is kept for the next byte.
      if (byte_start && full)
        full <= 1'b0;
      else if (i_TX_DV && !full) begin
        holding <= i_TX_Byte;
        full    <= 1'b1;
      end

      // Mid-frame byte starts fall on a sample edge, so the next shift edge must be
      // skipped to keep the fresh MSB; with CPHA=1 the first leading edge is always skipped.
      if (drop) begin
        tx_shift <= '0;
        skip     <= 1'b0;
      end else if (byte_start) begin
        tx_shift <= full ? holding : IDLE_FILL;
        skip     <= CPHA || (state == ACTIVE);
      end else if (live && shift_edge) begin
        if (skip) skip     <= 1'b0;
        else      tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (!live) begin
        cnt      <= '0;
        rx_shift <= '0;
      end else if (samp) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        cnt      <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          rx_byte <= {rx_shift[6:0], mosi_s};
          rx_dv   <= 1'b1;
        end
      end
    end
  end

  assign o_SPI_MISO = tx_shift[7];
  assign o_MISO_En  = (state == ACTIVE);
  assign o_RX_DV    = rx_dv;
  assign o_RX_Byte  = rx_byte;
  assign o_TX_Ready = !full;
endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: one instance per SPI mode, a bit-banged master, and a
// byte-level model (RX = bytes sent, MISO = queued bytes in order, then idle fill).
module tb_spi_slave_byte;
  localparam int         SYNC = 2;
  localparam int         HP   = 8;
  localparam logic [7:0] FILL = 8'hFF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      sck, cs_n, miso, miso_en, rx_dv, tx_dv, tx_rdy;
  logic            mosi;
  logic [7:0]      tx_byte;
  logic [3:0][7:0] rx_byte;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_byte #(.SPI_MODE(g), .SYNC_STAGES(SYNC), .IDLE_FILL(FILL)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_Clk(sck[g]), .i_SPI_CS_n(cs_n[g]),
      .i_SPI_MOSI(mosi), .o_SPI_MISO(miso[g]), .o_MISO_En(miso_en[g]),
      .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]), .i_TX_DV(tx_dv[g]),
      .i_TX_Byte(tx_byte), .o_TX_Ready(tx_rdy[g]));
  end

  int         n_chk, n_fail, cyc, cur, dv_cyc, samp_cyc;
  logic       rdy_low, en_seen;
  logic [7:0] mo [8];
  logic [7:0] mi [8];
  logic [7:0] rxq[$];
  logic [7:0] txl[$];
  logic [7:0] expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rx_dv[cur]) begin
      rxq.push_back(rx_byte[cur]);
      dv_cyc = cyc;
    end
    if (!tx_rdy[cur]) rdy_low = 1'b1;
  end

  task automatic spi_frame(input int m, input int nbits);
    bit cpol, cpha;
    cpol = ((m >> 1) & 1) == 1;
    cpha = (m & 1) == 1;
    for (int k = 0; k < 8; k++) mi[k] = 8'h00;
    @(negedge clk);
    cs_n[m] = 1'b0;
    if (!cpha) mosi = mo[0][7];
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck[m] = ~cpol;
      if (cpha) mosi = mo[i/8][7-(i%8)];
      else begin
        mi[i/8][7-(i%8)] = miso[m];
        samp_cyc = cyc;
        en_seen &= miso_en[m];
      end
      repeat (HP) @(negedge clk);
      sck[m] = cpol;
      if (cpha) begin
        mi[i/8][7-(i%8)] = miso[m];
        samp_cyc = cyc;
        en_seen &= miso_en[m];
      end else if (i + 1 < nbits) mosi = mo[(i+1)/8][7-((i+1)%8)];
      repeat (HP) @(negedge clk);
    end
    cs_n[m] = 1'b1;
    repeat (4*HP) @(negedge clk);
  endtask

  // Loads queued TX bytes one at a time, each as soon as the holding register frees up.
  task automatic feed(input int m);
    while (txl.size() > 0) begin
      int t = 0;
      while (!tx_rdy[m] && t < 4000) begin
        @(negedge clk);
        t++;
      end
      check("feed_rdy", tx_rdy[m], 1);
      if (!tx_rdy[m]) break;
      tx_byte = txl.pop_front();
      tx_dv[m] = 1'b1;
      @(negedge clk);
      tx_dv[m] = 1'b0;
      @(negedge clk);
    end
    txl.delete();
  endtask

  task automatic do_frame(input int m, input int nbits);
    cur = m;
    rxq.delete();
    rdy_low = 1'b0;
    en_seen = 1'b1;
    fork
      spi_frame(m, nbits);
      feed(m);
    join
  endtask

  task automatic check_frame(input string tag, input int nb);
    logic [7:0] e;
    check({tag, "_nrx"}, rxq.size(), nb);
    check({tag, "_en"}, en_seen, 1);
    for (int k = 0; k < nb; k++) begin
      e = (k < expq.size()) ? expq[k] : FILL;
      check({tag, "_miso"}, mi[k], e);
      if (k < rxq.size()) check({tag, "_rx"}, rxq[k], mo[k]);
    end
  endtask

  initial begin
    int m, nb, nt, d;
    rst_n = 1'b0;
    sck = 4'b1100; cs_n = 4'hF; mosi = 1'b0; tx_dv = 4'h0; tx_byte = 8'h00; cur = 0;
    repeat (3) @(negedge clk);
    check("rst_rx_dv", rx_dv, 0);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_en", miso_en, 0);
    check("rst_tx_rdy", tx_rdy, 4'hF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0 with queued A5, plus RX latency
    mo[0] = 8'h61; txl = '{8'hA5}; expq = txl;
    do_frame(0, 8);
    check_frame("m0_a5", 1);
    d = dv_cyc - samp_cyc;
    check("m0_latency", (d > 0 && d <= SYNC + 2), 1);
    check("m0_rdy_after", tx_rdy[0], 1);

    // Nothing queued: idle fill, ready never drops
    mo[0] = 8'h3C; expq.delete();
    do_frame(0, 8);
    check_frame("m0_fill", 1);
    check("m0_rdy_low", rdy_low, 0);

    // Three bytes in one frame, refilled as ready rises
    mo[0] = 8'h61; mo[1] = 8'h62; mo[2] = 8'h63;
    txl = '{8'h01, 8'h02, 8'h03}; expq = txl;
    do_frame(0, 24);
    check_frame("m0_b2b", 3);

    // CS released after 5 bits, then a clean byte
    mo[0] = 8'hFF; expq.delete();
    do_frame(0, 5);
    check("part_nrx", rxq.size(), 0);
    check("part_en", miso_en[0], 0);
    mo[0] = 8'h7E;
    do_frame(0, 8);
    check_frame("part_next", 1);

    // Modes 1..3 round-trip; a load while not ready must be ignored
    for (int mm = 1; mm < 4; mm++) begin
      cur = mm;
      txl = '{8'hC3};
      feed(mm);
      check("mode_rdy0", tx_rdy[mm], 0);
      tx_byte = 8'h55; tx_dv[mm] = 1'b1;
      @(negedge clk);
      tx_dv[mm] = 1'b0;
      @(negedge clk);
      check("mode_ign_rdy", tx_rdy[mm], 0);
      mo[0] = 8'hC3; expq = '{8'hC3};
      do_frame(mm, 8);
      check_frame("mode_c3", 1);
    end

    // Reset in the middle of a byte
    cur = 0;
    txl = '{8'h11};
    feed(0);
    cs_n[0] = 1'b0; mosi = 1'b1;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sck[0] = 1'b1; repeat (HP) @(negedge clk);
      sck[0] = 1'b0; repeat (HP) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("mrst_rx_byte", rx_byte[0], 0);
    check("mrst_miso", miso[0], 0);
    check("mrst_miso_en", miso_en[0], 0);
    check("mrst_tx_rdy", tx_rdy[0], 1);
    check("mrst_rx_dv", rx_dv[0], 0);
    @(negedge clk);
    cs_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mo[0] = 8'h5A; expq.delete();
    do_frame(0, 8);
    check_frame("mrst_next", 1);

    // Randomized frames across all modes
    for (int r = 0; r < 10; r++) begin
      m  = $urandom_range(3);
      nb = $urandom_range(3, 1);
      nt = $urandom_range(nb, 0);
      for (int k = 0; k < nb; k++) mo[k] = 8'($urandom);
      txl.delete();
      for (int k = 0; k < nt; k++) txl.push_back(8'($urandom));
      expq = txl;
      do_frame(m, nb * 8);
      check_frame("rand", nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
